adder_wide_sched: RTL
=====================

# adder_wide_sched

Sequencer and two-port arbiter for the 16-bit prefix adder core. Accepts WORDS×16-bit add requests from two requesters, grants one at a time round-robin, and feeds the single combinational 16-bit adder one slice per cycle, least significant slice first. Each slice's carry-out is registered and used as the next slice's carry-in. The finished wide sum is returned on a valid/ready response port. The block sits between the request fabric and the adder instance; the adder itself is external.

## Interface
- WORDS, 4, number of 16-bit slices per operation (≥1); operand width W = 16·WORDS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- req0_cin / req1_cin  in  1  carry-in to slice 0
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_sum  out  W  wide sum
- resp_cout  out  1  carry-out of the last slice
- resp_id  out  1  requester that issued the operation (0/1)
- add_a, add_b  out  16  slice operands to the adder core
- add_cin  out  1  slice carry-in to the adder core
- add_sum  in  16  adder core sum (combinational, same cycle)
- add_cout  in  1  adder core carry-out (combinational, same cycle)

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate: if exactly one reqN_valid, grant N. If both are valid, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational and never asserted outside IDLE.
  - On handshake: latch a, b, cin and id; set slice index k=0; go to RUN; set last_grant=N.
- RUN (one slice per cycle):
  - add_a = a[16k+:16]; add_b = b[16k+:16].
  - add_cin = (k==0) ? latched cin : carry_reg.
  - On the clock edge: sum_reg[16k+:16] <= add_sum; carry_reg <= add_cout; k <= k+1.
  - After slice WORDS-1, go to DONE.
- DONE:
  - resp_valid=1; resp_sum, resp_cout (= final carry_reg) and resp_id are held stable.
  - On resp_valid&&resp_ready, go to IDLE and drop resp_valid.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Arithmetic is modulo 2^W. The carry out of the top slice appears only on resp_cout.
- Requests are never dropped or reordered per requester. A request is consumed only on its handshake.
- Operand inputs are sampled only at the handshake. Changes after acceptance have no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert) forces:
  - state=IDLE, k=0, carry_reg=0, sum_reg=0, resp_cout=0, resp_id=0, resp_valid=0.
  - add_a, add_b, add_cin = 0.
  - last_grant=1, so req0 wins the first contention.
- Latency: handshake at edge T, RUN occupies cycles T+1…T+WORDS, resp_valid rises at cycle T+WORDS+1.
- Minimum issue interval is WORDS+2 cycles: one DONE cycle with immediate resp_ready, then one IDLE cycle. There is no accept in the same cycle as the response handshake.
- resp_ready held low: DONE persists indefinitely, outputs stay stable, both reqN_ready stay 0.
- Reset asserted mid-RUN or in DONE: the operation is discarded, no response is issued, and all outputs return to their reset values immediately.
- resp_ready high while resp_valid is low has no effect.

## Configuration
- ADDER_SCHED_SUB_EN defined:
  - Adds ports req0_sub / req1_sub (in, 1), latched at the handshake.
  - When sub=1, add_b = ~b slice and the slice-0 carry-in is forced to 1; reqN_cin is ignored.
  - resp_sum = a−b mod 2^W; resp_cout = 1 means no borrow.
- Undefined: the sub ports do not exist and only addition is performed.

## Test plan
- WORDS=4; req0 a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → resp_sum=0x0000_0000_0001_0000, cout=0, id=0; resp_valid exactly 5 cycles after the handshake.
- req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → resp_sum=0, cout=1, id=1. Checks the full 4-slice carry ripple through carry_reg.
- Both valids held high for 4 operations with resp_ready=1 → grant order 0,1,0,1; resp_id sequence 0,1,0,1; each result matches its operands.
- resp_ready low for 10 cycles in DONE → resp_sum, resp_cout, resp_id unchanged and both reqN_ready=0 throughout; the response completes on the cycle resp_ready rises.
- rst_n pulsed low while k=2 → all outputs zero immediately and no response issued. A subsequent req0 a=3, b=4 → sum=7.
- With ADDER_SCHED_SUB_EN: sub=1, a=5, b=7 → resp_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 → sum=2, cout=1.

Source files
------------

// File: rtl/adder_wide_sched.sv
// Two-requester round-robin sequencer that drives an external 16-bit adder one slice per cycle.
// Optional subtract mode is enabled by defining ADDER_SCHED_SUB_EN.
`timescale 1ns/1ps

module adder_wide_sched #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [16*WORDS-1:0]   req0_a,
    input  logic [16*WORDS-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [16*WORDS-1:0]   req1_a,
    input  logic [16*WORDS-1:0]   req1_b,
    input  logic                  req1_cin,
`ifdef ADDER_SCHED_SUB_EN
    input  logic                  req0_sub,
    input  logic                  req1_sub,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [16*WORDS-1:0]   resp_sum,
    output logic                  resp_cout,
    output logic                  resp_id,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cin_q;
    logic            carry_q;
    logic            id_q;
    logic            last_grant_q;
    logic            sub_q;

    logic            grant_c;
    logic            accept_c;
    logic            run_c;
    logic            sub_in_c;
    logic [15:0]     a_slice_c;
    logic [15:0]     b_slice_c;

    // Round-robin: on contention the requester that did not win last time is granted
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign req0_ready = (state_q == S_IDLE) && !grant_c;
    assign req1_ready = (state_q == S_IDLE) &&  grant_c;
    assign accept_c   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef ADDER_SCHED_SUB_EN
    assign sub_in_c = grant_c ? req1_sub : req0_sub;
`else
    assign sub_in_c = 1'b0;
`endif

    always_comb begin
        a_slice_c = '0;
        b_slice_c = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (k_q == KW'(i)) begin
                a_slice_c = a_q[16*i +: 16];
                b_slice_c = b_q[16*i +: 16];
            end
        end
    end

    // Adder-core drive is derived from registered state only, and is zero outside RUN
    assign run_c   = (state_q == S_RUN);
    assign add_a   = run_c ? a_slice_c : 16'h0000;
    assign add_b   = run_c ? (sub_q ? ~b_slice_c : b_slice_c) : 16'h0000;
    assign add_cin = run_c && ((k_q == '0) ? cin_q : carry_q);

    assign resp_valid = (state_q == S_DONE);
    assign resp_sum   = sum_q;
    assign resp_cout  = carry_q;
    assign resp_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cin_q        <= 1'b0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            sub_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q          <= grant_c ? req1_a : req0_a;
                        b_q          <= grant_c ? req1_b : req0_b;
                        // Subtraction is a + ~b + 1, so the slice-0 carry is forced high
                        cin_q        <= sub_in_c | (grant_c ? req1_cin : req0_cin);
                        sub_q        <= sub_in_c;
                        id_q         <= grant_c;
                        last_grant_q <= grant_c;
                        k_q          <= '0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < int'(WORDS); i++) begin
                        if (k_q == KW'(i)) begin
                            sum_q[16*i +: 16] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (k_q == KW'(WORDS - 1)) begin
                        k_q     <= '0;
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
